uart_tx_serializer: RTL and testbench

- Drains the TX sync FIFO through its read port and serializes each byte onto the UART tx line as start, data (LSB first), optional parity and stop bits.
- Sits between the TX FIFO read side and the pad. It is the consumer end of the FIFO handshake, honouring the FIFO's 1-cycle registered read latency.
- The bit clock is derived internally from a programmable divisor.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_baud_gen.sv | 41 ++++
 rtl/uart_tx_serializer.sv | 152 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART transmit shared types and helpers.
// Frame state encoding, data-length encoding and parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        DB5,
        DB6,
        DB7,
        DB8
    } data_bits_e;

    localparam int BYTE_W = 8;

    function automatic logic [3:0] data_bit_count(data_bits_e db);
        return 4'd5 + {2'b00, db};
    endfunction

    function automatic logic [BYTE_W-1:0] data_mask(data_bits_e db);
        return 8'hFF >> (4'd8 - data_bit_count(db));
    endfunction

    function automatic logic frame_parity(
        logic [BYTE_W-1:0] d,
        data_bits_e        db,
        logic              odd
    );
        return (^(d & data_mask(db))) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
// Divisor is captured on load; bit_end marks the last clk of each bit.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 run,
    output logic                 bit_end
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;

    assign bit_end = run && (cnt == div_q);

    // Hold the divisor for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (load) begin
            div_q <= div_in;
        end
    end

    // Count clks within a bit; restart at each bit end so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load || !run || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer fed from the TX FIFO read port.
// Sends start, 5-8 data bits LSB first, optional parity, 1-2 stop bits.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic [1:0]            cfg_data_bits,
    input  logic                  cfg_parity_en,
    input  logic                  cfg_parity_odd,
    input  logic                  cfg_stop2,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    tx_state_e         state;
    tx_state_e         state_nx;
    logic [BYTE_W-1:0] shreg;
    logic [2:0]        bit_cnt;
    data_bits_e        db_q;
    logic              par_en_q;
    logic              stop2_q;
    logic              par_bit_q;
    logic              tx_done_q;
    logic              bit_end;
    logic              run;
    logic              load;
    logic              last_data;
    logic              last_stop;
    data_bits_e        db_in;

    assign db_in     = data_bits_e'(cfg_data_bits);
    assign load      = (state == LOAD);
    assign run       = (state == START) || (state == DATA) ||
                       (state == PARITY) || (state == STOP);
    assign last_data = ({1'b0, bit_cnt} == (data_bit_count(db_q) - 4'd1));
    assign last_stop = (bit_cnt == {2'b00, stop2_q});
    assign tx_done   = tx_done_q;

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .div_in  (baud_div),
        .run     (run),
        .bit_end (bit_end)
    );

    // State register; reset aborts any frame and returns the line to idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nx   = state;
        tx         = 1'b1;
        fifo_rd_en = 1'b0;
        tx_busy    = 1'b1;
        unique case (state)
            IDLE: begin
                tx_busy = 1'b0;
                if (tx_en && !fifo_rd_empty) begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                fifo_rd_en = 1'b1;
                state_nx   = LOAD;
            end
            LOAD: begin
                state_nx = START;
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_nx = DATA;
                end
            end
            DATA: begin
                tx = shreg[0];
                if (bit_end && last_data) begin
                    state_nx = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                tx = par_bit_q;
                if (bit_end) begin
                    state_nx = STOP;
                end
            end
            STOP: begin
                if (bit_end && last_stop) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Frame datapath: capture byte and config, shift data, count bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            db_q      <= DB5;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (load) begin
            shreg     <= fifo_rd_data[BYTE_W-1:0];
            bit_cnt   <= '0;
            db_q      <= db_in;
            par_en_q  <= cfg_parity_en;
            stop2_q   <= cfg_stop2;
            par_bit_q <= frame_parity(fifo_rd_data[BYTE_W-1:0],
                                      db_in, cfg_parity_odd);
        end else if (state == DATA && bit_end) begin
            shreg   <= shreg >> 1;
            bit_cnt <= last_data ? 3'd0 : bit_cnt + 3'd1;
        end else if (state == STOP && bit_end) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // One-cycle done pulse in the first idle cycle after the last stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_done_q <= 1'b0;
        end else begin
            tx_done_q <= (state == STOP) && bit_end && last_stop;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer.
// Frame-level waveform model plus literal timing/pattern pins.
module tb_uart_tx_serializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_en = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic [1:0]  cfg_data_bits = 2'd3;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_stop2 = 1'b0;
    logic        fifo_rd_en;
    logic [7:0]  fifo_rd_data = 8'd0;
    logic        fifo_rd_empty = 1'b1;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    uart_tx_serializer #(
        .DATA_WIDTH (8),
        .DIV_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .tx_en          (tx_en),
        .baud_div       (baud_div),
        .cfg_data_bits  (cfg_data_bits),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_stop2      (cfg_stop2),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_empty  (fifo_rd_empty),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // FIFO contents and model state
    logic [7:0] fifo_q[$];
    logic       exp_q[$];
    logic [7:0] cur_byte = 8'd0;
    int         phase = 0;
    logic       done_exp = 1'b0;

    // Event log
    int   cyc = 0;
    int   rd_cnt = 0;
    int   done_cnt = 0;
    int   rd_at[$];
    int   fall_at[$];
    int   done_at[$];
    logic armed = 1'b0;
    logic txlog[4096];

    task automatic build_frame();
        int n;
        logic par;
        logic lv[$];
        n = 5 + int'(cfg_data_bits);
        lv.push_back(1'b0);
        par = cfg_parity_odd;
        for (int i = 0; i < n; i++) begin
            lv.push_back(cur_byte[i]);
            par = par ^ cur_byte[i];
        end
        if (cfg_parity_en) lv.push_back(par);
        lv.push_back(1'b1);
        if (cfg_stop2) lv.push_back(1'b1);
        foreach (lv[k]) begin
            for (int r = 0; r <= int'(baud_div); r++) begin
                exp_q.push_back(lv[k]);
            end
        end
    endtask

    // Model advance at the clock edge, compare on the falling edge.
    initial begin
        logic e_tx, e_rd, e_busy, e_done;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                phase = 0;
                exp_q.delete();
                done_exp = 1'b0;
            end else begin
                done_exp = 1'b0;
                case (phase)
                    0: if (tx_en && fifo_q.size() > 0) phase = 1;
                    1: phase = 2;
                    2: begin
                        build_frame();
                        phase = 3;
                    end
                    default: begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) begin
                            phase = 0;
                            done_exp = 1'b1;
                        end
                    end
                endcase
            end
            @(negedge clk);
            cyc++;
            e_tx = 1'b1; e_rd = 1'b0; e_busy = 1'b1; e_done = 1'b0;
            case (phase)
                0: begin e_busy = 1'b0; e_done = done_exp; end
                1: e_rd = 1'b1;
                2: ;
                default: e_tx = exp_q[0];
            endcase
            chk("tx", tx, e_tx);
            chk("fifo_rd_en", fifo_rd_en, e_rd);
            chk("tx_busy", tx_busy, e_busy);
            chk("tx_done", tx_done, e_done);
            chk("rd_on_empty", fifo_rd_en & fifo_rd_empty, 0);
            txlog[cyc % 4096] = tx;
            if (fifo_rd_en === 1'b1) begin
                rd_cnt++;
                rd_at.push_back(cyc);
                armed = 1'b1;
                if (fifo_q.size() > 0) begin
                    cur_byte = fifo_q.pop_front();
                    fifo_rd_data = cur_byte;
                end
                fifo_rd_empty = (fifo_q.size() == 0);
            end
            if (armed && tx === 1'b0) begin
                fall_at.push_back(cyc);
                armed = 1'b0;
            end
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_at.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr();
        rd_cnt = 0;
        done_cnt = 0;
        rd_at.delete();
        fall_at.delete();
        done_at.delete();
        armed = 1'b0;
    endtask

    task automatic push(logic [7:0] b);
        fifo_q.push_back(b);
        fifo_rd_empty = 1'b0;
    endtask

    task automatic cfg(int db, logic pe, logic po, logic s2, int dv);
        cfg_data_bits  = 2'(db);
        cfg_parity_en  = pe;
        cfg_parity_odd = po;
        cfg_stop2      = s2;
        baud_div       = 16'(dv);
    endtask

    task automatic wait_done(int n, int budget);
        int i = 0;
        while (done_cnt < n && i < budget) begin
            tick();
            i++;
        end
        chk("done_timeout", done_cnt >= n, 1);
    endtask

    task automatic wait_rd(int n, int budget);
        int i = 0;
        while (rd_cnt < n && i < budget) begin
            tick();
            i++;
        end
        chk("rd_timeout", rd_cnt >= n, 1);
    endtask

    initial begin
        logic [10:0] pat7;
        pat7 = 11'b11101000110;

        // Reset values
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rd", fifo_rd_en, 0);
        chk("rst_done", tx_done, 0);
        ticks(3);
        rst_n = 1'b1;

        // Empty FIFO with tx enabled: nothing happens
        clr();
        tx_en = 1'b1;
        ticks(20);
        chk("empty_rd_cnt", rd_cnt, 0);
        chk("empty_tx", tx, 1);

        // 0x55, 8N1, divisor 3
        clr();
        cfg(3, 0, 0, 0, 3);
        push(8'h55);
        wait_done(1, 100);
        ticks(5);
        chk("f55_rd_cnt", rd_cnt, 1);
        chk("f55_done_cnt", done_cnt, 1);
        if (rd_at.size() > 0 && fall_at.size() > 0 && done_at.size() > 0) begin
            chk("f55_rd_to_start", fall_at[0] - rd_at[0], 2);
            chk("f55_len", done_at[0] - fall_at[0], 40);
            for (int i = 0; i < 10; i++) begin
                chk("f55_bit", txlog[(fall_at[0] + 4 * i + 2) % 4096], i % 2);
            end
        end else begin
            chk("f55_events", 0, 1);
        end

        // 0xA3, 7E2, divisor 0
        clr();
        cfg(2, 1, 0, 1, 0);
        push(8'hA3);
        wait_done(1, 100);
        ticks(3);
        if (fall_at.size() > 0 && done_at.size() > 0) begin
            chk("fa3_len", done_at[0] - fall_at[0], 11);
            for (int i = 0; i < 11; i++) begin
                chk("fa3_bit", txlog[(fall_at[0] + i) % 4096], pat7[i]);
            end
        end else begin
            chk("fa3_events", 0, 1);
        end

        // Back-to-back 0x12, 0x34
        clr();
        cfg(3, 0, 0, 0, 1);
        push(8'h12);
        push(8'h34);
        wait_done(2, 200);
        ticks(5);
        chk("b2b_rd_cnt", rd_cnt, 2);
        chk("b2b_done_cnt", done_cnt, 2);
        if (fall_at.size() > 1 && done_at.size() > 0) begin
            chk("b2b_gap", fall_at[1] - done_at[0], 3);
        end else begin
            chk("b2b_events", 0, 1);
        end

        // Config change mid-frame
        clr();
        cfg(3, 0, 0, 0, 1);
        push(8'h0F);
        wait_rd(1, 20);
        ticks(10);
        cfg(0, 1, 1, 1, 2);
        push(8'h1B);
        wait_done(2, 300);
        ticks(3);
        if (fall_at.size() > 1 && done_at.size() > 1) begin
            chk("cfg_len1", done_at[0] - fall_at[0], 20);
            chk("cfg_len2", done_at[1] - fall_at[1], 27);
        end else begin
            chk("cfg_events", 0, 1);
        end

        // tx_en dropped mid-frame
        clr();
        cfg(3, 0, 0, 0, 1);
        push(8'h77);
        push(8'h88);
        wait_rd(1, 20);
        ticks(8);
        tx_en = 1'b0;
        wait_done(1, 100);
        ticks(20);
        chk("txen_rd_cnt", rd_cnt, 1);
        chk("txen_done_cnt", done_cnt, 1);
        chk("txen_fifo_left", fifo_q.size(), 1);
        fifo_q.delete();
        fifo_rd_empty = 1'b1;

        // Async reset during DATA
        clr();
        cfg(3, 0, 0, 0, 3);
        push(8'hC3);
        tx_en = 1'b1;
        wait_rd(1, 20);
        ticks(12);
        chk("pre_rst_busy", tx_busy, 1);
        tx_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", tx, 1);
        chk("arst_busy", tx_busy, 0);
        ticks(3);
        rst_n = 1'b1;
        ticks(5);
        chk("post_rst_done_cnt", done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
